// File: rtl/latch_gate_pkg.sv
// latch_gate_pkg: shared state encoding, timer width and parameter
// defaults for latch_gate_driver and its phase_timer.
package latch_gate_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    OPEN  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int TW            = 4;
  localparam int DEF_WIDTH     = 8;
  localparam int DEF_SETUP_CYC = 1;
  localparam int DEF_OPEN_CYC  = 2;
  localparam int DEF_HOLD_CYC  = 1;

  // A phase of n cycles loads n-1; done is seen on its last cycle.
  function automatic logic [TW-1:0] phase_load(input int n);
    return TW'(n - 1);
  endfunction

endpackage

// File: rtl/latch_gate_driver_phase_timer.sv
// phase_timer: 4-bit loadable down-counter, done while count is zero.
// Ports: clock, reset (sync, high), load, load_val[3:0], done.
module phase_timer
  import latch_gate_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          done
);

  logic [TW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/latch_gate_driver.sv
// latch_gate_driver: sequences d_out/gate for a level-sensitive latch
// through SETUP -> OPEN -> HOLD phases, counting finished transfers.
// Ports: clock, reset (sync, high), in_valid/in_data/in_ready (input
// handshake), gate, d_out, busy, xfer_count[15:0].
// Macro LATCH_GATE_DRIVER_B2B_EN: accept the next word in the last
// HOLD cycle for back-to-back transfers.
module latch_gate_driver
  import latch_gate_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int OPEN_CYC  = DEF_OPEN_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             gate,
  output logic [WIDTH-1:0] d_out,
  output logic             busy,
  output logic [15:0]      xfer_count
);

  localparam logic [TW-1:0] LD_S = phase_load(SETUP_CYC);
  localparam logic [TW-1:0] LD_O = phase_load(OPEN_CYC);
  localparam logic [TW-1:0] LD_H = phase_load(HOLD_CYC);

  state_t        state;
  logic          t_done;
  logic          t_load;
  logic [TW-1:0] t_val;
  logic          last_hold;
  logic          accept;

  assign last_hold = (state == HOLD) && t_done;

`ifdef LATCH_GATE_DRIVER_B2B_EN
  assign in_ready = (state == IDLE) || last_hold;
`else
  assign in_ready = (state == IDLE);
`endif

  assign accept = in_valid && in_ready;
  assign gate   = (state == OPEN);
  assign busy   = (state != IDLE);

  // Timer reloads on entry to each phase.
  always_comb begin
    t_load = 1'b0;
    t_val  = '0;
    unique case (1'b1)
      accept: begin
        t_load = 1'b1;
        t_val  = LD_S;
      end
      (state == SETUP) && t_done: begin
        t_load = 1'b1;
        t_val  = LD_O;
      end
      (state == OPEN) && t_done: begin
        t_load = 1'b1;
        t_val  = LD_H;
      end
      default: ;
    endcase
  end

  phase_timer u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (t_load),
    .load_val (t_val),
    .done     (t_done)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      d_out      <= '0;
      xfer_count <= '0;
    end else begin
      if (accept) d_out <= in_data;
      unique case (state)
        IDLE:  if (accept) state <= SETUP;
        SETUP: if (t_done) state <= OPEN;
        OPEN:  if (t_done) state <= HOLD;
        HOLD: begin
          if (t_done) begin
            xfer_count <= xfer_count + 16'd1;
            // accept only possible here with back-to-back enabled
            state <= accept ? SETUP : IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_latch_gate_driver.sv
// tb_latch_gate_driver: directed vector table plus hand sequences for
// back-to-back spacing, non-default phase lengths and count wrap.
module tb_latch_gate_driver;

`ifdef LATCH_GATE_DRIVER_B2B_EN
  localparam bit B2B = 1'b1;
  localparam int GAP = 4;
`else
  localparam bit B2B = 1'b0;
  localparam int GAP = 5;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vld = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        rdy, gate, busy;
  logic [7:0]  dout;
  logic [15:0] cnt;

  logic        p_rst = 1'b1;
  logic        p_vld = 1'b0;
  logic [7:0]  p_din = 8'h00;
  logic        p_rdy, p_gate, p_busy;
  logic [7:0]  p_dout;
  logic [15:0] p_cnt;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  latch_gate_driver u_dut (
    .clock      (clk),
    .reset      (rst),
    .in_valid   (vld),
    .in_data    (din),
    .in_ready   (rdy),
    .gate       (gate),
    .d_out      (dout),
    .busy       (busy),
    .xfer_count (cnt)
  );

  latch_gate_driver #(
    .WIDTH     (8),
    .SETUP_CYC (3),
    .OPEN_CYC  (1),
    .HOLD_CYC  (2)
  ) u_p (
    .clock      (clk),
    .reset      (p_rst),
    .in_valid   (p_vld),
    .in_data    (p_din),
    .in_ready   (p_rdy),
    .gate       (p_gate),
    .d_out      (p_dout),
    .busy       (p_busy),
    .xfer_count (p_cnt)
  );

  typedef struct {
    logic        rst;
    logic        vld;
    logic [7:0]  din;
    logic        rdy;
    logic        gate;
    logic        busy;
    logic [7:0]  dout;
    logic [15:0] cnt;
  } vec_t;

  vec_t tv[17];

  function automatic vec_t mk(
    input logic r, input logic v, input logic [7:0] d,
    input logic er, input logic eg, input logic eb,
    input logic [7:0] ed, input logic [15:0] ec);
    vec_t t;
    t.rst = r; t.vld = v; t.din = d;
    t.rdy = er; t.gate = eg; t.busy = eb;
    t.dout = ed; t.cnt = ec;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  initial begin
    int rise[$];
    logic [7:0] rd[$];
    logic prev;

    tv[0]  = mk(1, 0, 8'h00, 1,   0, 0, 8'h00, 0);
    tv[1]  = mk(0, 1, 8'hA5, 0,   0, 1, 8'hA5, 0);
    tv[2]  = mk(0, 1, 8'h00, 0,   1, 1, 8'hA5, 0);
    tv[3]  = mk(0, 1, 8'hFF, 0,   1, 1, 8'hA5, 0);
    tv[4]  = mk(0, 0, 8'h00, B2B, 0, 1, 8'hA5, 0);
    tv[5]  = mk(0, 0, 8'hFF, 1,   0, 0, 8'hA5, 1);
    tv[6]  = mk(0, 0, 8'h3C, 1,   0, 0, 8'hA5, 1);
    tv[7]  = mk(0, 1, 8'h5A, 0,   0, 1, 8'h5A, 1);
    tv[8]  = mk(0, 0, 8'h00, 0,   1, 1, 8'h5A, 1);
    tv[9]  = mk(1, 0, 8'h00, 1,   0, 0, 8'h00, 0);
    tv[10] = mk(0, 0, 8'h00, 1,   0, 0, 8'h00, 0);
    tv[11] = mk(1, 1, 8'h77, 1,   0, 0, 8'h00, 0);
    tv[12] = mk(0, 1, 8'h77, 0,   0, 1, 8'h77, 0);
    tv[13] = mk(0, 0, 8'h00, 0,   1, 1, 8'h77, 0);
    tv[14] = mk(0, 0, 8'hFF, 0,   1, 1, 8'h77, 0);
    tv[15] = mk(0, 0, 8'h00, B2B, 0, 1, 8'h77, 0);
    tv[16] = mk(0, 0, 8'h00, 1,   0, 0, 8'h77, 1);

    for (int i = 0; i < 17; i++) begin
      rst = tv[i].rst;
      vld = tv[i].vld;
      din = tv[i].din;
      @(posedge clk); #1;
      chk($sformatf("v%0d.rdy", i),  rdy,  tv[i].rdy);
      chk($sformatf("v%0d.gate", i), gate, tv[i].gate);
      chk($sformatf("v%0d.busy", i), busy, tv[i].busy);
      chk($sformatf("v%0d.dout", i), dout, tv[i].dout);
      chk($sformatf("v%0d.cnt", i),  cnt,  tv[i].cnt);
    end

    // Streaming words with in_valid held high
    rst = 1'b1; vld = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; vld = 1'b1; din = 8'h11;
    prev = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (k == 0) din = 8'h22;
      if (gate && !prev) begin
        rise.push_back(k);
        rd.push_back(dout);
      end
      prev = gate;
    end
    vld = 1'b0;
    chk("b2b.npulse", rise.size() >= 2, 1);
    if (rise.size() >= 2) begin
      chk("b2b.first", rise[0], 1);
      chk("b2b.gap", rise[1] - rise[0], GAP);
      chk("b2b.d0", rd[0], 8'h11);
      chk("b2b.d1", rd[1], 8'h22);
    end
    for (int k = 0; k < 10 && busy; k++) begin
      @(posedge clk); #1;
    end
    chk("b2b.idle", busy, 0);

    // SETUP=3, OPEN=1, HOLD=2 instance
    @(posedge clk); #1;
    p_rst = 1'b0; p_vld = 1'b1; p_din = 8'hC3;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        p_vld = 1'b0;
        p_din = 8'h00;
        chk("par.dout", p_dout, 8'hC3);
      end
      chk($sformatf("par.gate%0d", k), p_gate, k == 3);
      chk($sformatf("par.busy%0d", k), p_busy, k < 6);
    end
    chk("par.rdy", p_rdy, 1);
    chk("par.cnt", p_cnt, 1);

    // Count wrap from a preloaded 0xFFFF
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    force u_dut.xfer_count = 16'hFFFF;
    @(negedge clk);
    release u_dut.xfer_count;
    #1;
    vld = 1'b1; din = 8'hE1;
    @(posedge clk); #1;
    vld = 1'b0;
    for (int k = 0; k < 10 && busy; k++) begin
      @(posedge clk); #1;
    end
    chk("wrap.idle", busy, 0);
    chk("wrap.dout", dout, 8'hE1);
    chk("wrap.cnt", cnt, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
